// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the integer register file family.
// The FP register file reuses these definitions together with the scoreboard.
package regfile_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [4:0]          regaddr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: flush beats write-clear, and reserve beats write-clear.
// rbusy is looked up from the registered bits and hidden when a write is forwarded.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int NRP      = 2,
  parameter int NWP      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRP*AW-1:0] ra,
  output logic [NRP-1:0]    rbusy,
  input  logic [NWP-1:0]    we,
  input  logic [NWP*AW-1:0] wa,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush
);

  localparam bit BYP = (BYPASS != 0);
  localparam bit ZR  = (ZERO_REG != 0);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (we[j]) busy_d[wa[j*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a new producer keeps the bit set.
      if (rsv_en) busy_d[rsv_addr] = 1'b1;
    end
    if (ZR) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rbusy
      logic [AW-1:0] ra_a;
      logic          hit;
      logic          rbusy_v;

      assign ra_a = ra[gi*AW +: AW];

      always_comb begin
        hit = 1'b0;
        for (int j = 0; j < NWP; j++) begin
          if (we[j] && (wa[j*AW +: AW] == ra_a)) hit = 1'b1;
        end
        rbusy_v = busy_q[ra_a] && !(BYP && hit);
      end

      assign rbusy[gi] = rbusy_v;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: flop storage, combinational reads with optional
// write forwarding, and a busy scoreboard for issue/writeback tracking.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRP      = 2,
  parameter int NWP      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  output logic [NRP-1:0]      rbusy,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wa,
  input  logic [NWP*XLEN-1:0] wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush
);

  localparam bit BYP = (BYPASS != 0);
  localparam bit ZR  = (ZERO_REG != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic [AW-1:0]   wa_a   [NWP];
  logic [XLEN-1:0] wd_a   [NWP];

  genvar gi;
  generate
    for (gi = 0; gi < NWP; gi++) begin : g_wport
      assign wa_a[gi] = wa[gi*AW +: AW];
      assign wd_a[gi] = wd[gi*XLEN +: XLEN];
    end
  endgenerate

  // Ports are visited in ascending order, so the highest port's update lands last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (we[j] && !(ZR && (wa_a[j] == '0))) regs_q[wa_a[j]] <= wd_a[j];
      end
    end
  end

  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rport
      logic [AW-1:0]   ra_a;
      logic [XLEN-1:0] rd_v;

      assign ra_a = ra[gi*AW +: AW];

      always_comb begin
        rd_v = regs_q[ra_a];
        if (BYP) begin
          for (int j = 0; j < NWP; j++) begin
            if (we[j] && (wa_a[j] == ra_a)) rd_v = wd_a[j];
          end
        end
        if (ZR && (ra_a == '0)) rd_v = '0;
      end

      assign rd[gi*XLEN +: XLEN] = rd_v;
    end
  endgenerate

  regfile_scoreboard #(
    .NREG     (NREG),
    .NRP      (NRP),
    .NWP      (NWP),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rbusy    (rbusy),
    .we       (we),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush)
  );

endmodule
